// File: rtl/histo_serial_rx.sv
// Receiver for the histogram serial link: oversamples sclk/sdata, deserialises
// MSB-first bin words and frames them by idle gaps on the serial clock.
module histo_serial_rx #(
    parameter int NUM_BINS    = 1024,
    parameter int BIN_W       = 24,
    parameter int IDLE_CYCLES = 64,
    parameter int IDX_W       = 10,
    parameter int SUM_W       = 34
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk_i,
    input  logic             sdata_i,
    input  logic             en_i,
    output logic             bin_valid_o,
    output logic [IDX_W-1:0] bin_idx_o,
    output logic [BIN_W-1:0] bin_data_o,
    output logic             frame_done_o,
    output logic             frame_err_o,
    output logic [SUM_W-1:0] frame_sum_o,
    output logic [15:0]      frame_cnt_o
);

    localparam int BIT_W = $clog2(BIN_W + 1);
    localparam int GAP_W = $clog2(IDLE_CYCLES + 1);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BIN_W - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BINS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CLOSE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               sclk_s1_r;
    logic               sclk_s2_r;
    logic               sclk_s3_r;
    logic               sdata_s1_r;
    logic               sdata_s2_r;
    logic [GAP_W-1:0]   gap_r;
    logic [BIN_W-1:0]   shift_r;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [CNT_W-1:0]   bin_cnt_r;
    logic [SUM_W-1:0]   acc_r;
    logic               ovf_r;

    logic               rise_s;
    logic [BIN_W-1:0]   word_s;
    logic               gap_hit_s;
    logic               good_s;

    assign rise_s    = sclk_s2_r & ~sclk_s3_r;
    assign word_s    = {shift_r[BIN_W-2:0], sdata_s2_r};
    // A rise in the same cycle as the gap limit keeps the frame open.
    assign gap_hit_s = (gap_r == GAP_MAX) & ~rise_s;
    assign good_s    = (bin_cnt_r == FULL_CNT) & (bit_cnt_r == {BIT_W{1'b0}}) & ~ovf_r;

    // Two-flop synchronisers plus an extra sclk stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s1_r  <= 1'b0;
            sclk_s2_r  <= 1'b0;
            sclk_s3_r  <= 1'b0;
            sdata_s1_r <= 1'b0;
            sdata_s2_r <= 1'b0;
        end else begin
            sclk_s1_r  <= sclk_i;
            sclk_s2_r  <= sclk_s1_r;
            sclk_s3_r  <= sclk_s2_r;
            sdata_s1_r <= sdata_i;
            sdata_s2_r <= sdata_s1_r;
        end
    end

    // Gap counter: cycles since the last sclk rise, saturating at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_r <= {GAP_W{1'b0}};
        end else if (rise_s) begin
            gap_r <= {GAP_W{1'b0}};
        end else if (gap_r != GAP_MAX) begin
            gap_r <= gap_r + GAP_W'(1);
        end else begin
            gap_r <= gap_r;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a dropped enable always returns to IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (en_i && rise_s) begin
                    next_state_s = RECV;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RECV: begin
                if (gap_hit_s) begin
                    next_state_s = CLOSE;
                end else begin
                    next_state_s = RECV;
                end
            end
            CLOSE:   next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
        if (!en_i) begin
            next_state_s = IDLE;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // Deserialiser, accumulator and registered output strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_r      <= {BIN_W{1'b0}};
            bit_cnt_r    <= {BIT_W{1'b0}};
            bin_cnt_r    <= {CNT_W{1'b0}};
            acc_r        <= {SUM_W{1'b0}};
            ovf_r        <= 1'b0;
            bin_valid_o  <= 1'b0;
            bin_idx_o    <= {IDX_W{1'b0}};
            bin_data_o   <= {BIN_W{1'b0}};
            frame_done_o <= 1'b0;
            frame_err_o  <= 1'b0;
            frame_sum_o  <= {SUM_W{1'b0}};
            frame_cnt_o  <= 16'd0;
        end else begin
            bin_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            frame_err_o  <= 1'b0;
            if (en_i) begin
                case (state_r)
                    IDLE: begin
                        if (rise_s) begin
                            shift_r   <= {{(BIN_W-1){1'b0}}, sdata_s2_r};
                            bit_cnt_r <= BIT_W'(1);
                            bin_cnt_r <= {CNT_W{1'b0}};
                            acc_r     <= {SUM_W{1'b0}};
                            ovf_r     <= 1'b0;
                        end
                    end
                    RECV: begin
                        if (rise_s) begin
                            shift_r <= word_s;
                            if (bit_cnt_r == LAST_BIT) begin
                                bit_cnt_r <= {BIT_W{1'b0}};
                                if (bin_cnt_r < FULL_CNT) begin
                                    bin_valid_o <= 1'b1;
                                    bin_data_o  <= word_s;
                                    bin_idx_o   <= bin_cnt_r[IDX_W-1:0];
                                    acc_r       <= acc_r + SUM_W'(word_s);
                                    bin_cnt_r   <= bin_cnt_r + CNT_W'(1);
                                end else begin
                                    ovf_r <= 1'b1;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                            end
                        end else if (gap_hit_s) begin
                            if (good_s) begin
                                frame_done_o <= 1'b1;
                                frame_sum_o  <= acc_r;
                                frame_cnt_o  <= frame_cnt_o + 16'd1;
                            end else begin
                                frame_err_o <= 1'b1;
                            end
                        end
                    end
                    CLOSE:   ;
                    default: ;
                endcase
            end
        end
    end

endmodule
